// File: rtl/mmm_pkg.sv
// Shared types for the fetch front-end: FSM state encoding and line geometry helper.
package mmm_pkg;

  typedef enum logic [1:0] {
    FQ_RESET   = 2'd0,
    FQ_REQ     = 2'd1,
    FQ_WAIT    = 2'd2,
    FQ_DISCARD = 2'd3
  } fetch_q_state_t;

  // Number of low address bits that select a byte within one cache line.
  function automatic int line_offset_bits(input int line_instr, input int ilen);
    return $clog2(line_instr) + $clog2(ilen / 8);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction buffer of {pc, instr}: up to LINE_INSTR pushes and one pop per
// cycle, with a synchronous clear used for redirects.
module fetch_queue
  import mmm_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ILEN       = 32,
  parameter int LINE_INSTR = 4,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic [$clog2(LINE_INSTR):0] push_count,
  input  logic [LINE_INSTR*ILEN-1:0] push_instr,
  input  logic [LINE_INSTR*XLEN-1:0] push_pc,
  input  logic                       pop,
  output logic [ILEN-1:0]            head_instr,
  output logic [XLEN-1:0]            head_pc,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ILEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      wr_ptr    <= wr_ptr + PW'(push_count);
      rd_ptr    <= rd_ptr + PW'(pop);
      occupancy <= occupancy + CW'(push_count) - CW'(pop);
    end
  end

  // Pushed entries arrive already compacted at slot 0..push_count-1.
  always_ff @(posedge clk) begin
    for (int j = 0; j < LINE_INSTR; j++) begin
      if (!rst && !clear && (j < int'(push_count))) begin
        instr_mem[wr_ptr + PW'(j)] <= push_instr[j*ILEN +: ILEN];
        pc_mem[wr_ptr + PW'(j)]    <= push_pc[j*XLEN +: XLEN];
      end
    end
  end

  assign head_instr = instr_mem[rd_ptr];
  assign head_pc    = pc_mem[rd_ptr];
  assign empty      = (occupancy == '0);

endmodule

// File: rtl/fetch_queue_ctrl.sv
// Fetch front-end: line requests, line unpacking into fetch_queue, issue handshake and
// flush redirect. Define FETCH_BYPASS_EN for a zero-latency response-to-issue path.
module fetch_queue_ctrl
  import mmm_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              ILEN       = 32,
  parameter int              LINE_INSTR = 4,
  parameter int              DEPTH      = 8,
  parameter logic [XLEN-1:0] BOOT_PC    = 32'h0000_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [XLEN-1:0]            flush_pc_i,
  output logic                       cache_req_valid_o,
  input  logic                       cache_req_ready_i,
  output logic [XLEN-1:0]            cache_req_addr_o,
  input  logic                       cache_resp_valid_i,
  input  logic [LINE_INSTR*ILEN-1:0] cache_resp_line_i,
  output logic                       issue_valid_o,
  input  logic                       issue_ready_i,
  output logic [ILEN-1:0]            issue_instr_o,
  output logic [XLEN-1:0]            issue_pc_o,
  output logic [$clog2(DEPTH):0]     occupancy_o
);

  localparam int IB   = ILEN / 8;
  localparam int IDX  = $clog2(LINE_INSTR);
  localparam int BOFF = $clog2(IB);
  localparam int CNTW = IDX + 1;
  localparam int OCCW = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] INSTR_MASK = ~XLEN'(IB - 1);
  localparam logic [XLEN-1:0] LINE_MASK  =
    ~((XLEN'(1) << line_offset_bits(LINE_INSTR, ILEN)) - XLEN'(1));

  fetch_q_state_t state, state_next;
  logic [XLEN-1:0]            fetch_pc;
  logic [XLEN-1:0]            line_base;
  logic [IDX-1:0]             offset;
  logic [OCCW-1:0]            occ;
  logic                       q_empty;
  logic [ILEN-1:0]            head_instr;
  logic [XLEN-1:0]            head_pc;
  logic                       req_fire;
  logic                       resp_take;
  logic                       byp_take;
  logic                       pop;
  logic [CNTW-1:0]            push_count;
  logic [LINE_INSTR*ILEN-1:0] push_instr;
  logic [LINE_INSTR*XLEN-1:0] push_pc;
  int                         first_idx;

  assign line_base         = fetch_pc & LINE_MASK;
  assign offset            = fetch_pc[BOFF +: IDX];
  assign cache_req_addr_o  = line_base;
  assign occupancy_o       = occ;
  assign cache_req_valid_o = !rst_i && (state == FQ_REQ) &&
                             (occ <= OCCW'(DEPTH - LINE_INSTR));
  assign req_fire          = cache_req_valid_o && cache_req_ready_i;
  assign resp_take         = !rst_i && !flush_i && (state == FQ_WAIT) && cache_resp_valid_i;
  assign pop               = !rst_i && !flush_i && !q_empty && issue_ready_i;

`ifdef FETCH_BYPASS_EN
  logic byp_valid;
  assign byp_valid     = resp_take && q_empty;
  assign byp_take      = byp_valid && issue_ready_i;
  assign issue_valid_o = byp_valid || (!rst_i && !flush_i && !q_empty);
  assign issue_instr_o = byp_valid ? cache_resp_line_i[int'(offset)*ILEN +: ILEN] : head_instr;
  assign issue_pc_o    = byp_valid ? fetch_pc : head_pc;
`else
  assign byp_take      = 1'b0;
  assign issue_valid_o = !rst_i && !flush_i && !q_empty;
  assign issue_instr_o = head_instr;
  assign issue_pc_o    = head_pc;
`endif

  // Compact the live part of the line (from the PC offset, minus any bypassed head).
  always_comb begin
    push_count = '0;
    push_instr = '0;
    push_pc    = '0;
    first_idx  = int'(offset) + (byp_take ? 1 : 0);
    if (resp_take) begin
      push_count = CNTW'(LINE_INSTR - first_idx);
      for (int j = 0; j < LINE_INSTR; j++) begin
        if (first_idx + j < LINE_INSTR) begin
          push_instr[j*ILEN +: ILEN] = cache_resp_line_i[(first_idx + j)*ILEN +: ILEN];
          push_pc[j*XLEN +: XLEN]    = line_base + XLEN'((first_idx + j) * IB);
        end
      end
    end
  end

  // A flush while a response is still owed parks in DISCARD; once the stale line has
  // arrived (even in the flush cycle itself) nothing is owed, so REQ avoids a deadlock.
  always_comb begin
    state_next = state;
    case (state)
      FQ_RESET:   state_next = FQ_REQ;
      FQ_REQ:     if (req_fire) state_next = FQ_WAIT;
      FQ_WAIT:    if (cache_resp_valid_i) state_next = FQ_REQ;
      FQ_DISCARD: if (cache_resp_valid_i) state_next = FQ_REQ;
      default:    state_next = FQ_REQ;
    endcase
    if (flush_i) begin
      if (((state == FQ_WAIT || state == FQ_DISCARD) && !cache_resp_valid_i) || req_fire)
        state_next = FQ_DISCARD;
      else
        state_next = FQ_REQ;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= FQ_RESET;
      fetch_pc <= BOOT_PC & INSTR_MASK;
    end else begin
      state <= state_next;
      if (flush_i)
        fetch_pc <= flush_pc_i & INSTR_MASK;
      else if (resp_take)
        fetch_pc <= line_base + XLEN'(LINE_INSTR * IB);
    end
  end

  fetch_queue #(
    .XLEN       (XLEN),
    .ILEN       (ILEN),
    .LINE_INSTR (LINE_INSTR),
    .DEPTH      (DEPTH)
  ) u_queue (
    .clk        (clk_i),
    .rst        (rst_i),
    .clear      (flush_i),
    .push_count (push_count),
    .push_instr (push_instr),
    .push_pc    (push_pc),
    .pop        (pop),
    .head_instr (head_instr),
    .head_pc    (head_pc),
    .occupancy  (occ),
    .empty      (q_empty)
  );

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Randomized scoreboard bench for fetch_queue_ctrl; honours FETCH_BYPASS_EN when defined.
module tb_fetch_queue_ctrl;

  localparam int          XLEN  = 32;
  localparam int          ILEN  = 32;
  localparam int          LI    = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BOOT  = 32'h0000_0100;
  localparam int          NCYC  = 4000;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [31:0]  flush_pc;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         resp_valid;
  logic [127:0] resp_line;
  logic         issue_valid;
  logic         issue_ready;
  logic [31:0]  issue_instr;
  logic [31:0]  issue_pc;
  logic [3:0]   occ;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  item_t       sb[$];
  int          vectors = 0;
  int          miscompares = 0;

  // Reference model: fetch PC plus "request owed" / "owed line is stale" flags.
  bit          boot;
  bit          in_flight;
  bit          discard;
  logic [31:0] fpc;
  bit          exp_issue_valid = 1'b0;
  bit          exp_req;
  bit          resp_hit;
  bit          bypass_now;
  int          pend;
  bit          stall_mode;

  fetch_queue_ctrl #(
    .XLEN(XLEN), .ILEN(ILEN), .LINE_INSTR(LI), .DEPTH(DEPTH), .BOOT_PC(BOOT)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .flush_i            (flush),
    .flush_pc_i         (flush_pc),
    .cache_req_valid_o  (req_valid),
    .cache_req_ready_i  (req_ready),
    .cache_req_addr_o   (req_addr),
    .cache_resp_valid_i (resp_valid),
    .cache_resp_line_i  (resp_line),
    .issue_valid_o      (issue_valid),
    .issue_ready_i      (issue_ready),
    .issue_instr_o      (issue_instr),
    .issue_pc_o         (issue_pc),
    .occupancy_o        (occ)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushLine();
    int off;
    logic [31:0] base;
    off  = int'((fpc >> 2) & 32'h3);
    base = fpc & ~32'hF;
    for (int k = off; k < LI; k++)
      sb.push_back('{pc: base + 32'(4 * k), instr: resp_line[k*32 +: 32]});
  endtask

  task automatic applyStimulus(input int cyc);
    if (cyc % 50 == 0) stall_mode = ($urandom_range(0, 2) == 0);
    rst         = (cyc < 3) || (cyc >= 2000 && cyc < 2003);
    flush       = ($urandom_range(0, 24) == 0);
    flush_pc    = 32'h200 + 32'($urandom_range(0, 255));
    req_ready   = ($urandom_range(0, 3) != 0);
    issue_ready = stall_mode ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
    resp_line   = {$urandom, $urandom, $urandom, $urandom};
    resp_valid  = 1'b0;
    if (pend == 0) begin
      resp_valid = 1'b1;
      pend = -1;
    end else if (pend > 0) begin
      pend--;
    end else if (!in_flight && $urandom_range(0, 15) == 0) begin
      resp_valid = 1'b1;
    end
  endtask

  task automatic modelUpdate();
    bit fire;
    if (rst) begin
      sb.delete();
      fpc       = BOOT & ~32'h3;
      boot      = 1'b1;
      in_flight = 1'b0;
      discard   = 1'b0;
      pend      = -1;
    end else begin
      fire = exp_req && req_ready;
      if (flush) begin
        sb.delete();
        fpc = flush_pc & ~32'h3;
        if ((in_flight && !resp_valid) || fire) begin
          in_flight = 1'b1;
          discard   = 1'b1;
        end else begin
          in_flight = 1'b0;
          discard   = 1'b0;
        end
        if (fire) pend = $urandom_range(0, 3);
      end else if (fire) begin
        in_flight = 1'b1;
        discard   = 1'b0;
        pend      = $urandom_range(0, 3);
      end else if (in_flight && resp_valid) begin
        if (!discard) begin
          if (!bypass_now) pushLine();
          fpc = (fpc & ~32'hF) + 32'h10;
        end
        in_flight = 1'b0;
        discard   = 1'b0;
      end
      boot = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; flush_pc = '0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_line = '0; issue_ready = 1'b0;
    stall_mode = 1'b0;
    fpc = BOOT & ~32'h3; boot = 1'b1; in_flight = 1'b0; discard = 1'b0; pend = -1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      applyStimulus(cyc);
      #1;
      exp_req = !rst && !boot && !in_flight && (sb.size() <= DEPTH - LI);
      checkOutput("req_valid", 64'(req_valid), 64'(exp_req));
      checkOutput("req_addr", 64'(req_addr), 64'(fpc & ~32'hF));
      checkOutput("occupancy", 64'(occ), 64'(sb.size()));
      resp_hit   = !rst && in_flight && !discard && resp_valid && !flush;
      bypass_now = 1'b0;
`ifdef FETCH_BYPASS_EN
      if (resp_hit && sb.size() == 0) bypass_now = 1'b1;
`endif
      exp_issue_valid = (!rst && !flush && sb.size() > 0) || bypass_now;
      if (bypass_now) pushLine();
      #2;
      modelUpdate();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Monitor: checks the issue handshake and retires scoreboard entries on each accepted pop.
  initial forever begin
    item_t e;
    @(negedge clk);
    #2;
    checkOutput("issue_valid", 64'(issue_valid), 64'(exp_issue_valid));
    if (issue_valid && issue_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL issue_unexpected: got pc 0x%0h, expected no instruction at %0t",
                 issue_pc, $time);
      end else begin
        e = sb.pop_front();
        checkOutput("issue_pc", 64'(issue_pc), 64'(e.pc));
        checkOutput("issue_instr", 64'(issue_instr), 64'(e.instr));
      end
    end
  end

endmodule
